// File: rtl/pattern_resp_pkg.sv
// Shared types and defaults for the pattern response compactor.
// Maps the registered pattern outputs onto resp_in bit positions.
package pattern_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int          RESP_W_DEF = 10;
    localparam int          SIG_W_DEF  = 16;
    localparam logic [15:0] POLY_DEF   = 16'h1021;
    localparam logic [15:0] SEED_DEF   = 16'h0000;

    localparam int BIT_G42         = 0;
    localparam int BIT_N_572       = 1;
    localparam int BIT_N_573       = 2;
    localparam int BIT_N_549       = 3;
    localparam int BIT_N_569       = 4;
    localparam int BIT_N_452       = 5;
    localparam int BIT_ACVQN2      = 6;
    localparam int BIT_N_266_AND_0 = 7;
    localparam int BIT_ACVQN1      = 8;
    localparam int BIT_P6          = 9;

    // One MISR step on a w-bit register held in the low bits of s.
    // Callers truncate the result to w bits, so upper bits may be junk.
    function automatic logic [31:0] misr_step(
        input logic [31:0] s,
        input logic [31:0] d,
        input logic [31:0] p,
        input int          w
    );
        return (s << 1) ^ (s[w-1] ? p : 32'd0) ^ d;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift/XOR datapath only.
// Load has priority over enable; reset returns to SEED.
module misr_core
    import pattern_resp_pkg::*;
#(
    parameter int              SIG_W  = SIG_W_DEF,
    parameter int              DATA_W = RESP_W_DEF,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [SIG_W-1:0]  i_load_val,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [SIG_W-1:0]  o_misr
);

    logic [SIG_W-1:0] r_misr;
    logic [SIG_W-1:0] w_next;

    assign w_next = SIG_W'(misr_step(32'(r_misr), 32'(i_data),
                                     32'(POLY), SIG_W));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misr <= SEED;
        end else if (i_load) begin
            r_misr <= i_load_val;
        end else if (i_en) begin
            r_misr <= w_next;
        end
    end

    assign o_misr = r_misr;

endmodule

// File: rtl/pattern_resp_misr.sv
// Folds a window of pattern responses into a MISR signature with readout.
// Optional golden compare (sig_match) enabled by PATTERN_RESP_GOLDEN_EN.
module pattern_resp_misr
    import pattern_resp_pkg::*;
#(
    parameter int               RESP_W  = RESP_W_DEF,
    parameter int               SIG_W   = SIG_W_DEF,
    parameter int               WIN_LEN = 256,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(SEED_DEF)
`ifdef PATTERN_RESP_GOLDEN_EN
    ,
    parameter logic [SIG_W-1:0] GOLDEN  = '0
`endif
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              abort,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_in,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [SIG_W-1:0]  sig_out,
    output logic              busy,
    output logic [15:0]       sample_cnt
`ifdef PATTERN_RESP_GOLDEN_EN
    ,
    output logic              sig_match
`endif
);

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic             r_sig_valid;
    logic [SIG_W-1:0] r_sig_out;
    logic [SIG_W-1:0] w_misr;
    logic [SIG_W-1:0] w_misr_next;
    logic             w_load;
    logic             w_en;
    logic             w_last;

    assign w_load = (r_state == IDLE) & start;
    assign w_en   = (r_state == RUN) & resp_valid & ~abort;
    assign w_last = (r_cnt == 16'(WIN_LEN - 1));

    // Same step the core applies, so the signature is ready on the last edge
    assign w_misr_next = SIG_W'(misr_step(32'(w_misr), 32'(resp_in),
                                          32'(POLY), SIG_W));

    misr_core #(
        .SIG_W  (SIG_W),
        .DATA_W (RESP_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .i_clk      (blif_clk_net),
        .i_rst      (blif_reset_net),
        .i_load     (w_load),
        .i_load_val (SEED),
        .i_en       (w_en),
        .i_data     (resp_in),
        .o_misr     (w_misr)
    );

`ifdef PATTERN_RESP_GOLDEN_EN
    logic r_sig_match;
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_sig_match <= 1'b0;
        end else if (r_state == RUN && !abort && resp_valid && w_last) begin
            r_sig_match <= (w_misr_next == GOLDEN);
        end else if (r_state == HOLD && (abort || sig_ready)) begin
            r_sig_match <= 1'b0;
        end
    end
    assign sig_match = r_sig_match;
`endif

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_sig_valid <= 1'b0;
            r_sig_out   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt   <= 16'd0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_cnt   <= 16'd0;
                        r_state <= IDLE;
                    end else if (resp_valid) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_sig_valid <= 1'b1;
                            r_sig_out   <= w_misr_next;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        r_cnt       <= 16'd0;
                        r_sig_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (sig_ready) begin
                        r_sig_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sig_valid  = r_sig_valid;
    assign sig_out    = r_sig_out;
    assign busy       = (r_state == RUN);
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Bench for pattern_resp_misr: four configurations, shared stimulus,
// signatures predicted by polynomial division over GF(2).
module tb_pattern_resp_misr;

    localparam int          NDUT = 4;
    localparam int          WL [NDUT] = '{1, 2, 1, 4};
    localparam logic [15:0] SD [NDUT] = '{16'h0000, 16'h0000,
                                          16'h8000, 16'h0000};
    localparam logic [15:0] GD [NDUT] = '{16'h03FF, 16'h0000,
                                          16'h1021, 16'h0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        rv;
    logic        ready;
    logic [9:0]  rin;
    logic        sv  [NDUT];
    logic [15:0] so  [NDUT];
    logic        bsy [NDUT];
    logic [15:0] cnt [NDUT];
`ifdef PATTERN_RESP_GOLDEN_EN
    logic        sm  [NDUT];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pattern_resp_misr #(
            .RESP_W  (10),
            .SIG_W   (16),
            .WIN_LEN (WL[g]),
            .POLY    (16'h1021),
            .SEED    (SD[g])
`ifdef PATTERN_RESP_GOLDEN_EN
            ,
            .GOLDEN  (GD[g])
`endif
        ) u_dut (
            .blif_clk_net   (clk),
            .blif_reset_net (rst),
            .start          (start),
            .abort          (abort),
            .resp_valid     (rv),
            .resp_in        (rin),
            .sig_valid      (sv[g]),
            .sig_ready      (ready),
            .sig_out        (so[g]),
            .busy           (bsy[g]),
            .sample_cnt     (cnt[g])
`ifdef PATTERN_RESP_GOLDEN_EN
            ,
            .sig_match      (sm[g])
`endif
        );
    end

    // Signature as remainder arithmetic: multiply by x, reduce by x^16+POLY.
    function automatic logic [15:0] model_sig(input logic [15:0] seed,
                                             input logic [9:0] dq[$]);
        int unsigned m;
        m = seed;
        foreach (dq[i]) begin
            m = m * 2;
            if (m >= 32'h10000) m = m ^ 32'h11021;
            m = m ^ dq[i];
        end
        return m[15:0];
    endfunction

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rv = 1'b0; ready = 1'b0; rin = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_window(input int d, input logic [9:0] dq[$],
                             input int gap_max, input int hold_n,
                             input bit combo_abort);
        logic [15:0] exp;
        int          gaps;
        exp = model_sig(SD[d], dq);
        start = 1'b1; abort = combo_abort;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (bsy[d] !== 1'b1 || cnt[d] !== 16'd0) begin
            n_fail++;
            $display("FAIL start d%0d busy=%b cnt=%0d want busy=1 cnt=0",
                     d, bsy[d], cnt[d]);
        end
        for (int i = 0; i < dq.size(); i++) begin
            gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gaps) begin
                rv = 1'b0; rin = 10'($urandom);
                start = 1'($urandom);
                @(posedge clk); #1;
                n_checks++;
                if (cnt[d] !== 16'(i) || sv[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap d%0d cnt=%0d sv=%b want cnt=%0d sv=0",
                             d, cnt[d], sv[d], i);
                end
            end
            rv = 1'b1; rin = dq[i]; start = 1'($urandom);
            @(posedge clk); #1;
        end
        rv = 1'b0; start = 1'b0;
        n_checks++;
        if (sv[d] !== 1'b1 || so[d] !== exp || cnt[d] !== 16'(dq.size())
            || bsy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL sig d%0d sv=%b sig=%h cnt=%0d busy=%b want 1 %h %0d 0",
                     d, sv[d], so[d], cnt[d], bsy[d], exp, dq.size());
        end
`ifdef PATTERN_RESP_GOLDEN_EN
        n_checks++;
        if (sm[d] !== (exp == GD[d])) begin
            n_fail++;
            $display("FAIL match d%0d got=%b want=%b",
                     d, sm[d], (exp == GD[d]));
        end
`endif
        repeat (hold_n) begin
            ready = 1'b0; rv = 1'($urandom); rin = 10'($urandom);
            start = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (sv[d] !== 1'b1 || so[d] !== exp
                || cnt[d] !== 16'(dq.size())) begin
                n_fail++;
                $display("FAIL hold d%0d sv=%b sig=%h cnt=%0d want 1 %h %0d",
                         d, sv[d], so[d], cnt[d], exp, dq.size());
            end
        end
        rv = 1'b0; start = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        n_checks++;
        if (sv[d] !== 1'b0 || so[d] !== exp || bsy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL accept d%0d sv=%b sig=%h busy=%b want 0 %h 0",
                     d, sv[d], so[d], bsy[d], exp);
        end
`ifdef PATTERN_RESP_GOLDEN_EN
        n_checks++;
        if (sm[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL match_clr d%0d got=%b want=0", d, sm[d]);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        rv = 1'b1; ready = 1'b1; rin = 10'h3FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; rv = 1'b0; ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (sv[d] !== 1'b0 || so[d] !== 16'h0 || bsy[d] !== 1'b0
                || cnt[d] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset d%0d sv=%b sig=%h busy=%b cnt=%0d want 0",
                         d, sv[d], so[d], bsy[d], cnt[d]);
            end
        end
    endtask

    task automatic test_directed();
        logic [9:0] q[$];
        apply_reset();
        q = {10'h3FF};
        do_window(0, q, 0, 0, 1'b0);
        apply_reset();
        q = {10'h001, 10'h000};
        do_window(1, q, 0, 1, 1'b0);
        apply_reset();
        q = {10'h000};
        do_window(2, q, 0, 0, 1'b1);
    endtask

    task automatic test_hold_gaps();
        logic [9:0] q[$];
        apply_reset();
        q = {10'h155, 10'h2AA, 10'h3C3, 10'h0F0};
        do_window(3, q, 2, 5, 1'b0);
    endtask

    task automatic test_abort();
        logic [9:0] q[$];
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (k == 2 ? 3 : 2) begin
                rv = 1'b1; rin = 10'($urandom);
                @(posedge clk); #1;
            end
            n_checks++;
            if (cnt[3] !== 16'(k == 2 ? 3 : 2)) begin
                n_fail++;
                $display("FAIL pre_abort k%0d cnt=%0d", k, cnt[3]);
            end
            // k=0 abort, k=1 reset, k=2 abort racing the final sample
            rv = (k == 2); abort = (k != 1); rst = (k == 1);
            @(posedge clk); #1;
            rv = 1'b1; abort = 1'b0; rst = 1'b0;
            @(posedge clk); #1;
            rv = 1'b0;
            n_checks++;
            if (bsy[3] !== 1'b0 || cnt[3] !== 16'd0 || sv[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort k%0d busy=%b cnt=%0d sv=%b want 0 0 0",
                         k, bsy[3], cnt[3], sv[3]);
            end
        end
        q = {10'h3FF, 10'h001, 10'h200, 10'h0AB};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (q[i]) begin
            rv = 1'b1; rin = q[i];
            @(posedge clk); #1;
        end
        rv = 1'b0; abort = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; ready = 1'b0;
        n_checks++;
        if (sv[3] !== 1'b0 || cnt[3] !== 16'd0 || bsy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold sv=%b cnt=%0d busy=%b want 0 0 0",
                     sv[3], cnt[3], bsy[3]);
        end
        do_window(3, q, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        apply_reset();
        for (int w = 0; w < 8; w++) begin
            q = {};
            repeat (WL[3]) q.push_back(10'($urandom));
            do_window(3, q, 3, $urandom_range(4, 0), 1'($urandom));
            repeat ($urandom_range(2, 0)) begin
                rv = 1'b1; rin = 10'($urandom); abort = 1'($urandom);
                @(posedge clk); #1;
            end
            rv = 1'b0; abort = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_gaps();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
